io_input_queue: RTL and testbench
=================================

# io_input_queue

Input-side buffer for the stack processor. Accepts 16-bit words from an external producer over a valid/ready handshake, holds them in a small circular queue, and presents the two oldest words on `getin`/`getin2`, the processor's operand input ports. The processor consumes one or two words per cycle with pop strobes, so the queue decouples external input timing from the instruction stream.

## Interface

**Parameters**
- `DEPTH`, default 4: queue entries; power of two, ≥ 2.
- `WORD_W`, default 16: data width; matches processor word.

**Ports**
- `CLK` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low (0 = in reset).
- `in_data` in WORD_W: producer word.
- `in_valid` in 1: producer offers `in_data`.
- `in_ready` out 1: queue can accept this cycle.
- `pop1` in 1: processor consumed the head word.
- `pop2` in 1: processor consumed the head and second words.
- `getin` out WORD_W: oldest word (head); 0 when empty.
- `getin2` out WORD_W: second-oldest word; 0 when count < 2.
- `count` out clog2(DEPTH)+1: words held.
- `underflow_err` out 1: sticky; pop requested with too few words.

## Operation

- Storage: DEPTH×WORD_W register array. Write pointer `wp`, read pointer `rp`, and `count`, all registered. Pointers wrap modulo DEPTH through natural overflow of a clog2(DEPTH)-bit counter.
- Push accepted when `in_valid && in_ready`. The word is written at `mem[wp]` and `wp` increments.
- `in_ready = (count < DEPTH)`, computed from the registered count. There is no same-cycle pass-through: a full queue refuses a push even if a pop occurs in the same cycle.
- Pop amount `n`:
  - `pop2` gives n = 2; it overrides `pop1` if both are high.
  - Otherwise `pop1` gives n = 1.
  - Otherwise n = 0.
- Pop is legal only when n ≤ count. A legal pop advances `rp` by n.
- An illegal pop is ignored: `rp` and `count` are unchanged and `underflow_err` is set to 1. The flag clears only on reset.
- Count update: `count_next = count + push_accepted − (legal ? n : 0)`. Simultaneous push and pop are handled in the same cycle.
- Push into an empty queue with a same-cycle pop: the pop is illegal (count = 0), so the flag is set and the push is still accepted.
- Outputs:
  - `getin = (count ≥ 1) ? mem[rp] : 0`
  - `getin2 = (count ≥ 2) ? mem[rp+1] : 0`, index wrapping modulo DEPTH.

## Timing

- Reset asserted (asynchronous): `rp = wp = count = 0`, `underflow_err = 0`, `getin = getin2 = 0`, and `in_ready` forced to 0.
- Memory contents are not reset; the count-based masking hides them.
- After reset deasserts, `in_ready = 1` in the same cycle.
- Push latency is 1 cycle: a word accepted at edge k appears on `getin` (if it becomes head) from edge k onward.
- Pop effect is visible 1 cycle later: after edge k, `getin` shows the next word.
- `getin`/`getin2` are combinational from registered state; there are no input→output combinational paths.
- Reset asserted mid-operation discards all contents immediately. A handshake in progress on that edge is lost.

## Structure

- Package `stack_io_pkg` holds:
  - `WORD_W` = 16
  - a `qcount_t` typedef sized for DEPTH
  - a `pop_amt_e` enum (NONE, ONE, TWO)
- The processor shares `WORD_W` from this package.
- A single sub-module `io_queue_mem` (register array with one write port and two read ports) is natural. Pointer and count logic stays in the top module.

## Test plan

- **Reset:** hold `reset` = 0 with `in_valid` = 1 → `in_ready` = 0, `count` = 0, `getin` = `getin2` = 0. Release → `in_ready` = 1.
- **Fill and read:** push 2 then 3 → `getin` = 2, `getin2` = 3, `count` = 2. Assert `pop2` → next cycle `count` = 0, both outputs 0.
- **Full:** push 10, 11, 12, 13 → `count` = 4, `in_ready` = 0. Push 14 with `pop1` in the same cycle → 14 refused, `getin` = 11, `count` = 3.
- **Wrap-around:** repeat push/`pop1` for 9 words (values 1..9) → `getin` follows 1..9 in order with no loss or duplication across the pointer wrap.
- **Underflow:** `count` = 1 (word 7), assert `pop2` → `count` stays 1, `getin` = 7, `underflow_err` = 1 and stays 1 until reset.
- **Simultaneous push/pop:** `count` = 2 (5, 6), push 8 with `pop1` → `count` = 2, `getin` = 6, `getin2` = 8.

Source files
------------

// File: rtl/stack_io_pkg.sv
// Shared types and constants for the stack processor I/O blocks.
package stack_io_pkg;

   // Processor word width, shared by the core and its I/O queues.
   localparam int unsigned WORD_W = 16;

   // Default input queue depth and the matching occupancy type.
   localparam int unsigned QDEPTH = 4;
   typedef logic [$clog2(QDEPTH):0] qcount_t;

   // Number of words the processor consumes in one cycle.
   typedef enum logic [1:0] {
      NONE = 2'd0,
      ONE  = 2'd1,
      TWO  = 2'd2
   } pop_amt_e;

endpackage

// File: rtl/io_queue_mem.sv
// Register array with one write port and two asynchronous read ports.
module io_queue_mem #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WORD_W = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr0_i,
   output logic [WORD_W-1:0] rdata0_o,
   input  logic [AW-1:0]     raddr1_i,
   output logic [WORD_W-1:0] rdata1_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] mem_d [DEPTH];

   // Next-state of the array: only the addressed entry changes on a write.
   always_comb begin
      mem_d = mem_q;
      if (we_i) begin
         mem_d[waddr_i] = wdata_i;
      end
   end

   // Storage is not reset; the queue count masks stale entries.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign rdata0_o = mem_q[raddr0_i];
   assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/io_input_queue.sv
// Input-side circular queue presenting the two oldest words to the processor.
module io_input_queue
   import stack_io_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WORD_W = stack_io_pkg::WORD_W,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              pop1,
   input  logic              pop2,
   output logic [WORD_W-1:0] getin,
   output logic [WORD_W-1:0] getin2,
   output logic [CW-1:0]     count,
   output logic              underflow_err
);

   logic [AW-1:0]     wp_q, wp_d;
   logic [AW-1:0]     rp_q, rp_d;
   logic [CW-1:0]     count_q, count_d;
   logic              err_q, err_d;
   logic [WORD_W-1:0] head_data, second_data;
   logic [AW-1:0]     rp_next1;
   pop_amt_e          pop_amt;
   logic [CW-1:0]     pop_n;
   logic              push, legal;

   // Ready is held low while in reset, otherwise reflects free space.
   assign in_ready = reset && (count_q < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign rp_next1 = rp_q + AW'(1);

   // Decode pop strobes; pop2 takes priority over pop1.
   always_comb begin
      pop_amt = NONE;
      if (pop2) begin
         pop_amt = TWO;
      end else if (pop1) begin
         pop_amt = ONE;
      end
   end

   assign pop_n = CW'(pop_amt);
   assign legal = (pop_n <= count_q);

   // Pointer, count and sticky-error next state; an illegal pop is dropped.
   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q + CW'(push);
      err_d   = err_q | ~legal;
      if (push) begin
         wp_d = wp_q + AW'(1);
      end
      if (legal) begin
         rp_d    = rp_q + AW'(pop_n);
         count_d = count_d - pop_n;
      end
   end

   // Queue state registers.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   io_queue_mem #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
   ) u_mem (
      .clk_i    (CLK),
      .we_i     (push),
      .waddr_i  (wp_q),
      .wdata_i  (in_data),
      .raddr0_i (rp_q),
      .rdata0_o (head_data),
      .raddr1_i (rp_next1),
      .rdata1_o (second_data)
   );

   assign getin         = (count_q >= CW'(1)) ? head_data : '0;
   assign getin2        = (count_q >= CW'(2)) ? second_data : '0;
   assign count         = count_q;
   assign underflow_err = err_q;

endmodule

// File: tb/tb_io_input_queue.sv
// Randomized and directed bench for io_input_queue against a queue-based model.
module tb_io_input_queue;
   localparam int DEPTH = 4;
   localparam int W     = 16;

   logic          CLK = 1'b0;
   logic          reset;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic          pop1, pop2;
   logic [W-1:0]  getin, getin2;
   logic [2:0]    count;
   logic          underflow_err;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: plain FIFO of words plus sticky error bit.
   logic [W-1:0] mq[$];
   bit           merr;

   io_input_queue #(.DEPTH(DEPTH), .WORD_W(W)) dut (
      .CLK           (CLK),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .pop1          (pop1),
      .pop2          (pop2),
      .getin         (getin),
      .getin2        (getin2),
      .count         (count),
      .underflow_err (underflow_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      logic [W-1:0] e0, e1;
      e0 = (mq.size() >= 1) ? mq[0] : '0;
      e1 = (mq.size() >= 2) ? mq[1] : '0;
      check({tag, ".count"}, 32'(count), 32'(mq.size()));
      check({tag, ".getin"}, 32'(getin), 32'(e0));
      check({tag, ".getin2"}, 32'(getin2), 32'(e1));
      check({tag, ".ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
      check({tag, ".err"}, 32'(underflow_err), 32'(merr));
   endtask

   // One clock: drive inputs, apply the model on the edge, then compare.
   task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                        input logic p1, input logic p2);
      int  n;
      bit  acc;
      in_valid = v; in_data = d; pop1 = p1; pop2 = p2;
      @(posedge CLK);
      acc = v && (mq.size() < DEPTH);
      n   = p2 ? 2 : (p1 ? 1 : 0);
      if (n <= mq.size()) begin
         for (int i = 0; i < n; i++) void'(mq.pop_front());
      end else begin
         merr = 1'b1;
      end
      if (acc) mq.push_back(d);
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b1; in_data = 16'hdead; pop1 = 1'b0; pop2 = 1'b0;
      merr = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst.ready", 32'(in_ready), 32'd0);
      check("rst.count", 32'(count), 32'd0);
      check("rst.getin", 32'(getin), 32'd0);
      check("rst.getin2", 32'(getin2), 32'd0);
      in_valid = 1'b0;
      #1 reset = 1'b1;
      #1 check("rel.ready", 32'(in_ready), 32'd1);

      // Fill and read
      cycle("fill", 1, 16'd2, 0, 0);
      cycle("fill", 1, 16'd3, 0, 0);
      check("fill.g0", 32'(getin), 32'd2);
      check("fill.g1", 32'(getin2), 32'd3);
      cycle("pop2", 0, 0, 0, 1);
      check("pop2.count", 32'(count), 32'd0);

      // Full, then refused push with same-cycle pop
      for (int v = 10; v <= 13; v++) cycle("full", 1, W'(v), 0, 0);
      check("full.ready", 32'(in_ready), 32'd0);
      cycle("fullpush", 1, 16'd14, 1, 0);
      check("fullpush.g0", 32'(getin), 32'd11);
      check("fullpush.count", 32'(count), 32'd3);
      repeat (3) cycle("drain", 0, 0, 1, 0);

      // Wrap-around
      for (int v = 1; v <= 9; v++) begin
         cycle("wrap.push", 1, W'(v), 0, 0);
         check("wrap.head", 32'(getin), 32'(v));
         cycle("wrap.pop", 0, 0, 1, 0);
      end

      // Underflow
      cycle("uf.push", 1, 16'd7, 0, 0);
      cycle("uf.pop2", 0, 0, 0, 1);
      check("uf.count", 32'(count), 32'd1);
      check("uf.g0", 32'(getin), 32'd7);
      check("uf.err", 32'(underflow_err), 32'd1);
      cycle("uf.pop1", 0, 0, 1, 0);
      check("uf.sticky", 32'(underflow_err), 32'd1);

      // Simultaneous push/pop
      cycle("sim", 1, 16'd5, 0, 0);
      cycle("sim", 1, 16'd6, 0, 0);
      cycle("sim.pp", 1, 16'd8, 1, 0);
      check("sim.count", 32'(count), 32'd2);
      check("sim.g0", 32'(getin), 32'd6);
      check("sim.g1", 32'(getin2), 32'd8);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle("rand", ($urandom % 2) == 0, W'($urandom), ($urandom % 4) == 0,
               ($urandom % 7) == 0);
      end

      // Asynchronous reset mid-operation
      @(negedge CLK);
      reset = 1'b0;
      mq.delete(); merr = 1'b0;
      #1;
      check("arst.ready", 32'(in_ready), 32'd0);
      check("arst.count", 32'(count), 32'd0);
      check("arst.getin", 32'(getin), 32'd0);
      check("arst.err", 32'(underflow_err), 32'd0);
      @(posedge CLK);
      #2 reset = 1'b1;
      #1 check_all("arst.rel");

      for (int i = 0; i < 200; i++) begin
         cycle("rand2", ($urandom % 3) != 0, W'($urandom), ($urandom % 3) == 0,
               ($urandom % 12) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
